// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if
// Byte stream leaving the UART receiver.
//   data_out        : received byte, stable while data_out_valid is high
//   data_out_valid  : data_out holds a byte the consumer has not taken yet
//   data_out_ready  : consumer accepts the byte in the current cycle
// The receiver connects through the master modport and the consumer through
// the slave modport.
interface uart_rx_framer_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;

    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );
endinterface

// File: rtl/uart_rx_framer.sv
// uart_rx_framer
// 8N1 UART receiver. The asynchronous serial line is first synchronized, then
// a state machine finds the start bit, samples each data bit in the middle of
// its symbol and checks the stop bit. Finished bytes go out on a valid/ready
// stream with a single holding register.
// Ports:
//   clk            : sole clock, rising edge
//   rst            : asynchronous reset, active low
//   serial_in      : UART line, idle high
//   out_if         : byte stream (data_out, data_out_valid, data_out_ready)
//   framing_error  : one-cycle pulse when the stop bit is sampled low
//   overrun        : one-cycle pulse when a finished byte is dropped because
//                    the holding register is still full
module uart_rx_framer #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     serial_in,
    uart_rx_framer_if.master         out_if,
    output logic                     framing_error,
    output logic                     overrun
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME) + 1;

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       data_q;
    logic             valid_q;
    logic [1:0]       sync_q;
    logic             rx;

    // Two-flop synchronizer. Resetting to 1 makes the line look idle so a
    // reset release can never be mistaken for a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    assign rx = sync_q[1];

    // Receive state machine plus output holding register. The counter is
    // cleared at every bit boundary, so it only ever counts up to one symbol.
    // The start state waits half a symbol, which puts every later sample in
    // the middle of its bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            counter       <= '0;
            bit_idx       <= '0;
            shift_reg     <= 8'h00;
            data_q        <= 8'h00;
            valid_q       <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;

            // A consumer handshake empties the holding register. A byte that
            // completes in the same cycle overrides this below.
            if (valid_q && out_if.data_out_ready) begin
                valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    counter <= '0;
                    bit_idx <= '0;
                    if (!rx) begin
                        state <= START;
                    end
                end

                START: begin
                    if (counter == SAMPLE_LAST) begin
                        counter <= '0;
                        // A line that is high again by mid-start was a glitch.
                        if (rx) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                DATA: begin
                    if (counter == SYMBOL_LAST) begin
                        counter   <= '0;
                        shift_reg <= {rx, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                STOP: begin
                    if (counter == SYMBOL_LAST) begin
                        counter <= '0;
                        if (rx) begin
                            state <= IDLE;
                            // The holding register is free either when it is
                            // empty or when it is being drained this cycle.
                            if (!valid_q || out_if.data_out_ready) begin
                                data_q  <= shift_reg;
                                valid_q <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                            state         <= WAIT_HIGH;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    // A line stuck low after a bad stop bit (e.g. a break) must
                    // go high before another start bit is accepted.
                    counter <= '0;
                    bit_idx <= '0;
                    if (rx) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

    assign out_if.data_out       = data_q;
    assign out_if.data_out_valid = valid_q;

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 SHALL have port serial_in  input  1  asynchronous UART line, idle high.
REQ-006 SHALL have port data_out  output  8  received byte.
REQ-007 SHALL have port data_out_valid  output  1  data_out holds an unconsumed byte.
REQ-008 SHALL have port data_out_ready  input  1  consumer accepts the byte this cycle.
REQ-009 SHALL have port framing_error  output  1  one-cycle pulse when a bad stop bit is detected.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-011 SHALL define SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer division) and SAMPLE_TIME = SYMBOL_EDGE_TIME/2.
REQ-012 SHALL pass serial_in through a 2-flop synchronizer before use; all decisions use the synchronized line (rx).
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a cycle counter sized clog2(SYMBOL_EDGE_TIME)+1 bits.
REQ-014 IDLE: SHALL move to START, counter cleared, when rx==0.
REQ-015 START: at counter==SAMPLE_TIME-1, SHALL return to IDLE if rx==1 (glitch rejected, no output); otherwise SHALL clear counter and enter DATA.
REQ-016 DATA: at counter==SYMBOL_EDGE_TIME-1, SHALL sample rx into the shift register LSB first, clear counter, and after the 8th bit enter STOP.
REQ-017 STOP: at counter==SYMBOL_EDGE_TIME-1, SHALL sample rx; if 1, complete the byte and enter IDLE; if 0, pulse framing_error next cycle, drop the byte, and enter WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL enter IDLE only when rx==1; no start detection while rx stays low.
REQ-019 On byte completion with data_out_valid==0, SHALL load data_out and set data_out_valid on the next cycle.
REQ-020 Handshake: data_out_valid SHALL clear on the cycle after data_out_valid&&data_out_ready; data_out SHALL be stable while valid is high.
REQ-021 Completion in the same cycle as a handshake SHALL load the new byte with data_out_valid remaining 1 and no overrun.
REQ-022 Completion while valid==1 and no handshake SHALL keep the old data_out, drop the new byte, and pulse overrun for one cycle.
REQ-023 Counter SHALL never wrap: it is cleared at every bit boundary and in IDLE/WAIT_HIGH.
REQ-024 Receiver SHALL re-arm for the next start bit immediately on entering IDLE after the stop-bit sample, supporting back-to-back frames.

Reset
REQ-025 While rst==0: state=IDLE, counter=0, shift register=0, data_out=8'h00, data_out_valid=0, framing_error=0, overrun=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output; after release a new frame SHALL be received normally.

Verification (CLOCK_FREQ=50_000_000, BAUD_RATE=1_000_000: SYMBOL_EDGE_TIME=50, SAMPLE_TIME=25)
REQ-027 Frame 8'h61 with valid stop, ready=0 -> data_out_valid=1, data_out=8'h61 within 9.5 bit periods + 4 cycles of the start edge; held until ready pulse, then valid=0 next cycle.
REQ-028 serial_in low for 10 cycles then high -> no data_out_valid, no framing_error; following frame 8'h5A received correctly.
REQ-029 Frame 8'hA5 with stop bit 0 and line held low 3 bit periods -> framing_error pulse exactly 1 cycle, no valid; subsequent frame 8'h3C after line high received as 8'h3C.
REQ-030 Frames 8'h11 then 8'h22 back-to-back with ready=0 -> data_out stays 8'h11, overrun pulses 1 cycle at second completion.
REQ-031 Ten back-to-back frames 8'h61..8'h6A with ready=1 -> ten valid bytes in order, no errors.
REQ-032 rst=0 during DATA bit 4 for 5 cycles -> all outputs at reset values; next full frame 8'hC3 received correctly.
